vpu_dst_port: RTL and testbench

VPU_DST_PORT -- requirements
Module: vpu_dst_port

---
 rtl/vpu_pkg.sv | 14 +
 rtl/vpu_dst_fifo.sv | 60 ++++++
 rtl/vpu_dst_port.sv | 152 +++++++++++++++
 tb/tb_vpu_dst_port.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// Shared VPU definitions: datapath widths and the destination-port FSM state type.
package vpu_pkg;

    localparam int OPERAND_WIDTH   = 16;
    localparam int SRAM_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dst_state_e;

endpackage

// File: rtl/vpu_dst_fifo.sv
// Result buffer for the destination port: small synchronous FIFO with
// show-ahead head output, extra-bit pointers for full/empty detection.
module vpu_dst_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    // Push into a full buffer or pop from an empty one is dropped.
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign data_o  = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Pointer update; push and pop in the same cycle keep occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Storage is cleared on reset so the head output reads zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/vpu_dst_port.sv
// VPU destination port: buffers ALU results and streams them to SRAM at
// consecutive addresses starting from a latched base, for a latched count.
module vpu_dst_port
    import vpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [SRAM_ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]       len_i,
    input  logic [OPERAND_WIDTH-1:0]   result_i,
    input  logic                       result_valid_i,
    output logic                       result_ready_o,
    output logic                       sram_w_en_o,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_w_addr_o,
    output logic [OPERAND_WIDTH-1:0]   sram_w_data_o,
    input  logic                       sram_w_ready_i,
    output logic                       busy_o,
    output logic                       done_o
);

    dst_state_e                 r_state;
    logic                       r_busy;
    logic                       r_done;
    logic [SRAM_ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]       r_len;
    logic [LEN_WIDTH-1:0]       r_acc_cnt;
    logic [LEN_WIDTH-1:0]       r_wr_cnt;

    logic                       w_full;
    logic                       w_empty;
    logic                       w_ready;
    logic                       w_push;
    logic                       w_wen;
    logic                       w_pop;
    logic                       w_acc_last;
    logic                       w_wr_last;
    logic [OPERAND_WIDTH-1:0]   w_head;

    // Ready is built only from registered state, never from the SRAM handshake.
    assign w_ready    = (r_state == ST_RUN) && !w_full && (r_acc_cnt < r_len);
    assign w_push     = result_valid_i && w_ready;
    assign w_wen      = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !w_empty;
    assign w_pop      = w_wen && sram_w_ready_i;
    assign w_acc_last = (LEN_WIDTH'(r_acc_cnt + LEN_WIDTH'(1)) == r_len);
    assign w_wr_last  = (LEN_WIDTH'(r_wr_cnt + LEN_WIDTH'(1)) == r_len);

    assign result_ready_o = w_ready;
    assign sram_w_en_o    = w_wen;
    assign sram_w_data_o  = w_head;
    assign sram_w_addr_o  = r_base + SRAM_ADDR_WIDTH'(r_wr_cnt);
    assign busy_o         = r_busy;
    assign done_o         = r_done;

    vpu_dst_fifo #(
        .WIDTH (OPERAND_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (result_i),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Control FSM; busy/done are registered together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_acc_cnt == r_len) begin
                        // Only reachable with a zero length: nothing to write.
                        r_state <= w_empty ? ST_DONE : ST_DRAIN;
                        r_done  <= w_empty;
                    end else if (w_push && w_acc_last) begin
                        // Final result just accepted; buffer holds at least it.
                        r_state <= ST_DRAIN;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= ST_RUN;
                        r_done  <= 1'b0;
                    end
                    r_busy <= 1'b1;
                end
                ST_DRAIN: begin
                    if ((w_pop && w_wr_last) || w_empty) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_DRAIN;
                        r_done  <= 1'b0;
                    end
                    r_busy <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Transaction context: base/length latched on start, accept/write counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base    <= '0;
            r_len     <= '0;
            r_acc_cnt <= '0;
            r_wr_cnt  <= '0;
        end else if ((r_state == ST_IDLE) && start_i) begin
            r_base    <= dst_addr_i;
            r_len     <= len_i;
            r_acc_cnt <= '0;
            r_wr_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_acc_cnt <= r_acc_cnt + LEN_WIDTH'(1);
            end
            if (w_pop) begin
                r_wr_cnt <= r_wr_cnt + LEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_vpu_dst_port.sv
// Randomized self-checking bench for vpu_dst_port with a queue-based reference model.
module tb_vpu_dst_port;
    import vpu_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int LEN_WIDTH  = 16;
    localparam int ADDR_SPAN  = 1 << SRAM_ADDR_WIDTH;

    logic                       clk;
    logic                       rst_n;
    logic                       start_i;
    logic [SRAM_ADDR_WIDTH-1:0] dst_addr_i;
    logic [LEN_WIDTH-1:0]       len_i;
    logic [OPERAND_WIDTH-1:0]   result_i;
    logic                       result_valid_i;
    logic                       result_ready_o;
    logic                       sram_w_en_o;
    logic [SRAM_ADDR_WIDTH-1:0] sram_w_addr_o;
    logic [OPERAND_WIDTH-1:0]   sram_w_data_o;
    logic                       sram_w_ready_i;
    logic                       busy_o;
    logic                       done_o;

    vpu_dst_port #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .dst_addr_i     (dst_addr_i),
        .len_i          (len_i),
        .result_i       (result_i),
        .result_valid_i (result_valid_i),
        .result_ready_o (result_ready_o),
        .sram_w_en_o    (sram_w_en_o),
        .sram_w_addr_o  (sram_w_addr_o),
        .sram_w_data_o  (sram_w_data_o),
        .sram_w_ready_i (sram_w_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 accepting, 2 draining, 3 completion cycle.
    int                       m_phase;
    int                       m_base;
    int                       m_len;
    int                       m_acc;
    int                       m_wr;
    logic [OPERAND_WIDTH-1:0] q[$];

    int n_checks;
    int n_fail;
    int cyc_cnt;
    int n_writes;
    int n_dones;
    int first_done;
    int start_cyc;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc_cnt);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_base  = 0;
        m_len   = 0;
        m_acc   = 0;
        m_wr    = 0;
        q.delete();
    endtask

    // One clock: check outputs at the falling edge, advance the model, move past the rising edge.
    task automatic step();
        logic exp_ready;
        logic exp_wen;
        logic push;
        logic pop;
        @(negedge clk);
        exp_ready = (m_phase == 1) && (q.size() < FIFO_DEPTH) && (m_acc < m_len);
        exp_wen   = ((m_phase == 1) || (m_phase == 2)) && (q.size() > 0);
        chk_eq("result_ready", 32'(result_ready_o), 32'(exp_ready));
        chk_eq("w_en", 32'(sram_w_en_o), 32'(exp_wen));
        if (exp_wen) begin
            chk_eq("w_addr", 32'(sram_w_addr_o), 32'((m_base + m_wr) % ADDR_SPAN));
            chk_eq("w_data", 32'(sram_w_data_o), 32'(q[0]));
        end
        chk_eq("busy", 32'(busy_o), 32'(m_phase != 0));
        chk_eq("done", 32'(done_o), 32'(m_phase == 3));
        if (sram_w_en_o && sram_w_ready_i) n_writes++;
        if (done_o) begin
            n_dones++;
            if (first_done < 0) first_done = cyc_cnt;
        end
        push = result_valid_i && exp_ready;
        pop  = exp_wen && sram_w_ready_i;
        case (m_phase)
            0: if (start_i) begin
                   m_phase = 1;
                   m_base  = int'(dst_addr_i);
                   m_len   = int'(len_i);
                   m_acc   = 0;
                   m_wr    = 0;
               end
            1: if (m_acc == m_len) m_phase = (q.size() == 0) ? 3 : 2;
               else if (push && (m_acc + 1 == m_len)) m_phase = 2;
            2: if (pop && (m_wr + 1 == m_len)) m_phase = 2 + 1;
            3: m_phase = 0;
            default: m_phase = 0;
        endcase
        if (pop) begin
            void'(q.pop_front());
            m_wr++;
        end
        if (push) begin
            q.push_back(result_i);
            m_acc++;
        end
        cyc_cnt++;
        @(posedge clk);
        #1;
    endtask

    // One start-to-completion transaction with randomized handshakes.
    task automatic run_txn(input int base, input int len, input int pv, input int pw,
                           input int low, input int extra, input int seq);
        int c;
        n_writes       = 0;
        n_dones        = 0;
        first_done     = -1;
        start_cyc      = cyc_cnt;
        start_i        = 1'b1;
        dst_addr_i     = SRAM_ADDR_WIDTH'(base);
        len_i          = LEN_WIDTH'(len);
        result_valid_i = 1'b0;
        result_i       = '0;
        sram_w_ready_i = (low > 0) ? 1'b0 : 1'b1;
        step();
        c = 0;
        while ((m_phase != 0) && (c < 400)) begin
            start_i        = (extra != 0) && ($urandom_range(0, 3) == 0);
            dst_addr_i     = SRAM_ADDR_WIDTH'($urandom);
            len_i          = LEN_WIDTH'($urandom_range(0, 20));
            result_valid_i = ($urandom_range(0, 99) < pv);
            result_i       = (seq != 0) ? OPERAND_WIDTH'(seq + m_acc) : OPERAND_WIDTH'($urandom);
            sram_w_ready_i = (c < low) ? 1'b0 : ($urandom_range(0, 99) < pw);
            step();
            c++;
        end
        chk_eq("txn_finished", 32'(m_phase), 32'd0);
        chk_eq("txn_writes", 32'(n_writes), 32'(len));
        chk_eq("txn_done_pulses", 32'(n_dones), 32'd1);
        start_i        = 1'b0;
        result_valid_i = 1'b0;
        sram_w_ready_i = 1'b1;
        step();
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        cyc_cnt        = 0;
        n_writes       = 0;
        n_dones        = 0;
        first_done     = -1;
        start_cyc      = 0;
        model_reset();
        rst_n          = 1'b0;
        start_i        = 1'b0;
        dst_addr_i     = '0;
        len_i          = '0;
        result_i       = '0;
        result_valid_i = 1'b0;
        sram_w_ready_i = 1'b0;

        #2;
        chk_eq("reset_ready", 32'(result_ready_o), 32'd0);
        chk_eq("reset_w_en", 32'(sram_w_en_o), 32'd0);
        chk_eq("reset_w_addr", 32'(sram_w_addr_o), 32'd0);
        chk_eq("reset_w_data", 32'(sram_w_data_o), 32'd0);
        chk_eq("reset_busy", 32'(busy_o), 32'd0);
        chk_eq("reset_done", 32'(done_o), 32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();

        // Streaming: back-to-back results, SRAM always ready.
        run_txn(32'h010, 4, 100, 100, 0, 0, 32'hA1);
        chk_eq("stream_done_cycle", 32'(first_done - start_cyc), 32'd6);

        // Backpressure: SRAM stalled for 10 cycles, length 8.
        run_txn(32'h040, 8, 100, 100, 10, 0, 32'hB0);

        // Zero length: completion two cycles after the start pulse, no writes.
        run_txn(32'h055, 0, 100, 100, 0, 0, 0);
        chk_eq("zero_len_done_cycle", 32'(first_done - start_cyc), 32'd2);

        // Address wrap at the top of the SRAM space.
        run_txn(ADDR_SPAN - 2, 4, 100, 100, 0, 0, 32'hC0);

        // Start pulses while busy and valid held high past the length.
        run_txn(32'h100, 5, 100, 70, 0, 1, 0);

        // Reset with three results buffered, then restart.
        start_i        = 1'b1;
        dst_addr_i     = SRAM_ADDR_WIDTH'(32'h020);
        len_i          = LEN_WIDTH'(8);
        result_valid_i = 1'b0;
        sram_w_ready_i = 1'b0;
        step();
        start_i        = 1'b0;
        result_valid_i = 1'b1;
        for (int k = 0; (k < 20) && (q.size() < 3); k++) begin
            result_i = OPERAND_WIDTH'(32'hD0 + m_acc);
            step();
        end
        chk_eq("rst_buffered_entries", 32'(q.size()), 32'd3);
        rst_n = 1'b0;
        #1;
        chk_eq("rst_mid_w_en", 32'(sram_w_en_o), 32'd0);
        chk_eq("rst_mid_ready", 32'(result_ready_o), 32'd0);
        chk_eq("rst_mid_busy", 32'(busy_o), 32'd0);
        chk_eq("rst_mid_addr", 32'(sram_w_addr_o), 32'd0);
        chk_eq("rst_mid_data", 32'(sram_w_data_o), 32'd0);
        model_reset();
        result_valid_i = 1'b0;
        sram_w_ready_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_writes = 0;
        repeat (3) step();
        chk_eq("rst_idle_no_writes", 32'(n_writes), 32'd0);
        run_txn(32'h030, 6, 80, 80, 0, 0, 0);

        // Randomized transactions.
        for (int t = 0; t < 25; t++) begin
            run_txn($urandom_range(0, ADDR_SPAN - 1), $urandom_range(0, 12),
                    $urandom_range(30, 100), $urandom_range(20, 100),
                    $urandom_range(0, 6), $urandom_range(0, 1), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
